io_input_conditioner: RTL and testbench
=======================================

# io_input_conditioner

Conditions the raw board inputs (four 4-bit switch groups plus the `ctrl_plus` push-button) before they reach the port connector of the pipelined computer. Each input is synchronised into the `clock` domain, debounced with a programmable stability window, and packed into the two 32-bit input-port words read by the memory stage. It also emits a one-cycle button-press strobe, a wrapping press counter and an update strobe whenever either input-port word changes.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 250000, consecutive cycles a new value must hold before acceptance (≥2; 5 ms at 50 MHz)
- `CNT_W`, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
- `clock`  in  1  system clock, rising-edge
- `reset`  in  1  synchronous, active-high reset
- `in0_0`  in  4  raw switch group, low nibble of port 0
- `in0_1`  in  4  raw switch group, high nibble of port 0
- `in1_0`  in  4  raw switch group, low nibble of port 1
- `in1_1`  in  4  raw switch group, high nibble of port 1
- `ctrl_plus`  in  1  raw push-button, high = pressed
- `in_port0`  out  32  {24'b0, in0_1_db, in0_0_db}
- `in_port1`  out  32  {24'b0, in1_1_db, in1_0_db}
- `ctrl_level`  out  1  debounced button level
- `ctrl_pulse`  out  1  one-cycle strobe on debounced button press
- `press_count`  out  8  count of debounced presses, wraps 255→0
- `port_update`  out  1  one-cycle strobe when `in_port0` or `in_port1` changes

## Operation
- Five independent channels: four 4-bit groups and the 1-bit button. Each channel is a 2-flop synchroniser (`s1`, `s2`), then a debouncer holding `stable` and counter `cnt`.
- Debouncer, per clock edge:
  - `s2 == stable` → `cnt <= 0`.
  - `s2 != stable` and `cnt < DEBOUNCE_CYCLES-1` → `cnt <= cnt+1`.
  - `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1` → `stable <= s2`, `cnt <= 0`.
- A group is debounced as a whole bus. Any change of `s2` while counting restarts the window: `cnt <= 0` whenever `s2` differs from its previous-cycle value. A value toggling faster than the window is never accepted.
- `in_port0`/`in_port1` are combinational packings of the group `stable` registers. Upper 24 bits are always 0.
- `ctrl_level` = button `stable`.
- `ctrl_pulse` is registered. It is 1 for exactly the cycle in which `ctrl_level` first reads 1 after a 0→1 update, and 0 otherwise. A falling edge produces no pulse.
- `press_count` increments (mod 256) on the same edge that sets `ctrl_pulse`.
- `port_update` is registered. It is 1 for the single cycle in which any group's `stable` first shows a new value. Simultaneous updates of several groups give one pulse.
- Reset: all `s1`, `s2`, `stable`, `cnt` cleared; all outputs 0 (`in_port0 = in_port1 = 0`, `ctrl_level = ctrl_pulse = port_update = 0`, `press_count = 0`).
- Reset mid-count discards the pending value. Switches already non-zero at reset release are accepted through the normal path (one `port_update`).
- Reset while the button is held: after release from reset the held button is accepted normally and produces one `ctrl_pulse`.

## Timing
- Raw input changes before edge k and stays held: `s1` at k, `s2` at k+1, `cnt` counts at edges k+2 … k+DEBOUNCE_CYCLES. `stable` updates at edge k+DEBOUNCE_CYCLES+1.
- Total latency: the output shows the new value DEBOUNCE_CYCLES+2 edges after the raw change.
- `ctrl_pulse`/`port_update` rise on the same edge as the corresponding `stable` update and fall at the next edge.
- Minimum press-to-press spacing accepted: DEBOUNCE_CYCLES cycles high plus DEBOUNCE_CYCLES cycles low.
- No combinational path from raw inputs to any output.

## Test plan
All tests use `DEBOUNCE_CYCLES=4`.
- **Reset:** hold `reset` for 3 cycles with switches at 0xF → all outputs 0 during reset. After release, `in_port0 = 0x000000FF` at edge 6 after release, and `port_update` pulses once.
- **Clean press:** `ctrl_plus` 0→1 held for 10 cycles → `ctrl_level` rises 6 edges later, one `ctrl_pulse`, `press_count = 1`. Release → `ctrl_level` falls 6 edges later with no pulse.
- **Bounce rejection:** `ctrl_plus` toggles every 2 cycles for 20 cycles, then settles at 1 → exactly one `ctrl_pulse`, 6 edges after settling.
- **Simultaneous groups:** `in0_0 = 0x3` and `in1_1 = 0xA` on the same cycle → `in_port0 = 0x03` and `in_port1 = 0xA0` on the same edge, with a single `port_update`.
- **Counter wrap:** 256 clean presses → `press_count` goes 255→0, with 256 `ctrl_pulse` strobes.
- **Mid-window reset:** change `in1_0` to 0x5, assert `reset` 2 cycles later → `in_port1` stays 0 with no `port_update` during reset. Value is accepted 6 edges after reset release.

Source files
------------

// File: rtl/io_input_conditioner_if.sv
// Raw board inputs and conditioned input-port words exchanged with the conditioner.
interface io_input_conditioner_if;
   logic [3:0]  in0_0;
   logic [3:0]  in0_1;
   logic [3:0]  in1_0;
   logic [3:0]  in1_1;
   logic        ctrl_plus;
   logic [31:0] in_port0;
   logic [31:0] in_port1;
   logic        ctrl_level;
   logic        ctrl_pulse;
   logic [7:0]  press_count;
   logic        port_update;

   modport master (
      output in0_0, in0_1, in1_0, in1_1, ctrl_plus,
      input  in_port0, in_port1, ctrl_level, ctrl_pulse, press_count, port_update
   );

   modport slave (
      input  in0_0, in0_1, in1_0, in1_1, ctrl_plus,
      output in_port0, in_port1, ctrl_level, ctrl_pulse, press_count, port_update
   );
endinterface

// File: rtl/io_input_conditioner.sv
// Synchronises and debounces switch groups and the push-button, packs the
// stable switch values into the two input-port words and strobes on changes.
module io_input_conditioner_db #(
   parameter int unsigned W               = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned CNT_W           = 18
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] raw_i,
   output logic [W-1:0] stable_o,
   output logic         accept_o
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [W-1:0]     s1_q, s2_q, stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // s1 != s2 means s2 changes on this edge, so the window restarts from zero
   // and counting resumes only while s2 holds one value.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      accept_o = 1'b0;
      if (s2_q != stable_q) begin
         if (cnt_q == LAST) begin
            stable_d = s2_q;
            accept_o = 1'b1;
         end else if (s1_q == s2_q) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_q     <= '0;
         s2_q     <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
      end else begin
         s1_q     <= raw_i;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;
endmodule

module io_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned CNT_W           = 18
) (
   input logic                    clock,
   input logic                    reset,
   io_input_conditioner_if.slave  bus
);
   logic [3:0] st00, st01, st10, st11;
   logic [3:0] grp_acc;
   logic       btn_st, btn_acc;

   logic       pulse_q, pulse_d;
   logic       update_q, update_d;
   logic [7:0] count_q, count_d;

   io_input_conditioner_db #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db00 (
      .clock(clock), .reset(reset), .raw_i(bus.in0_0), .stable_o(st00), .accept_o(grp_acc[0]));
   io_input_conditioner_db #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db01 (
      .clock(clock), .reset(reset), .raw_i(bus.in0_1), .stable_o(st01), .accept_o(grp_acc[1]));
   io_input_conditioner_db #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db10 (
      .clock(clock), .reset(reset), .raw_i(bus.in1_0), .stable_o(st10), .accept_o(grp_acc[2]));
   io_input_conditioner_db #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db11 (
      .clock(clock), .reset(reset), .raw_i(bus.in1_1), .stable_o(st11), .accept_o(grp_acc[3]));
   io_input_conditioner_db #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_dbbtn (
      .clock(clock), .reset(reset), .raw_i(bus.ctrl_plus), .stable_o(btn_st), .accept_o(btn_acc));

   // An accepted button update always flips the level, so old level 0 marks a press.
   always_comb begin
      pulse_d  = btn_acc & ~btn_st;
      update_d = |grp_acc;
      count_d  = count_q;
      if (pulse_d) count_d = count_q + 8'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pulse_q  <= 1'b0;
         update_q <= 1'b0;
         count_q  <= '0;
      end else begin
         pulse_q  <= pulse_d;
         update_q <= update_d;
         count_q  <= count_d;
      end
   end

   assign bus.in_port0    = {24'b0, st01, st00};
   assign bus.in_port1    = {24'b0, st11, st10};
   assign bus.ctrl_level  = btn_st;
   assign bus.ctrl_pulse  = pulse_q;
   assign bus.press_count = count_q;
   assign bus.port_update = update_q;
endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with a 4-cycle debounce window.
module tb_io_input_conditioner;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pulse_seen = 0;
   int   upd_seen = 0;
   int   p0, u0;
   logic [7:0] exp_cnt;

   io_input_conditioner_if bus ();

   io_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      pulse_seen = pulse_seen + int'(bus.ctrl_pulse);
      upd_seen   = upd_seen + int'(bus.port_update);
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.in0_0 = 4'hF; bus.in0_1 = 4'hF; bus.in1_0 = 4'h0; bus.in1_1 = 4'h0;
      bus.ctrl_plus = 1'b0;

      // reset with switches already set
      tick(3);
      check("rst_port0", bus.in_port0, 32'h0);
      check("rst_port1", bus.in_port1, 32'h0);
      check("rst_level", 32'(bus.ctrl_level), 32'h0);
      check("rst_pulse", 32'(bus.ctrl_pulse), 32'h0);
      check("rst_update", 32'(bus.port_update), 32'h0);
      check("rst_count", 32'(bus.press_count), 32'h0);
      u0 = upd_seen;
      reset = 1'b0;
      tick(5);
      check("rel_port0_e5", bus.in_port0, 32'h0);
      tick(1);
      check("rel_port0_e6", bus.in_port0, 32'h0000_00FF);
      check("rel_update_e6", 32'(bus.port_update), 32'h1);
      tick(1);
      check("rel_update_e7", 32'(bus.port_update), 32'h0);
      check("rel_update_n", 32'(upd_seen - u0), 32'd1);

      // clean press and release
      p0 = pulse_seen;
      bus.ctrl_plus = 1'b1;
      tick(5);
      check("press_level_e5", 32'(bus.ctrl_level), 32'h0);
      tick(1);
      check("press_level_e6", 32'(bus.ctrl_level), 32'h1);
      check("press_pulse_e6", 32'(bus.ctrl_pulse), 32'h1);
      check("press_count", 32'(bus.press_count), 32'd1);
      tick(1);
      check("press_pulse_e7", 32'(bus.ctrl_pulse), 32'h0);
      tick(3);
      bus.ctrl_plus = 1'b0;
      tick(5);
      check("rel_level_e5", 32'(bus.ctrl_level), 32'h1);
      tick(1);
      check("rel_level_e6", 32'(bus.ctrl_level), 32'h0);
      tick(2);
      check("press_pulse_n", 32'(pulse_seen - p0), 32'd1);
      check("rel_count", 32'(bus.press_count), 32'd1);

      // bounce rejection
      p0 = pulse_seen;
      for (int i = 0; i < 10; i++) begin
         bus.ctrl_plus = ~bus.ctrl_plus;
         tick(2);
      end
      check("bounce_level", 32'(bus.ctrl_level), 32'h0);
      check("bounce_pulse_n0", 32'(pulse_seen - p0), 32'd0);
      bus.ctrl_plus = 1'b1;
      tick(5);
      check("settle_level_e5", 32'(bus.ctrl_level), 32'h0);
      tick(1);
      check("settle_pulse_e6", 32'(bus.ctrl_pulse), 32'h1);
      check("settle_count", 32'(bus.press_count), 32'd2);
      bus.ctrl_plus = 1'b0;
      tick(8);
      check("settle_pulse_n", 32'(pulse_seen - p0), 32'd1);

      // simultaneous group changes
      u0 = upd_seen;
      bus.in0_0 = 4'h3; bus.in0_1 = 4'h0; bus.in1_1 = 4'hA;
      tick(5);
      check("sim_port0_e5", bus.in_port0, 32'h0000_00FF);
      check("sim_port1_e5", bus.in_port1, 32'h0);
      tick(1);
      check("sim_port0_e6", bus.in_port0, 32'h0000_0003);
      check("sim_port1_e6", bus.in_port1, 32'h0000_00A0);
      check("sim_update_e6", 32'(bus.port_update), 32'h1);
      tick(1);
      check("sim_update_e7", 32'(bus.port_update), 32'h0);
      check("sim_update_n", 32'(upd_seen - u0), 32'd1);

      // counter wrap through 255 -> 0
      p0 = pulse_seen;
      exp_cnt = 8'd2;
      for (int i = 0; i < 256; i++) begin
         bus.ctrl_plus = 1'b1;
         tick(6);
         exp_cnt = exp_cnt + 8'd1;
         check("wrap_count", 32'(bus.press_count), 32'(exp_cnt));
         bus.ctrl_plus = 1'b0;
         tick(6);
      end
      check("wrap_pulse_n", 32'(pulse_seen - p0), 32'd256);

      // reset in the middle of a debounce window
      bus.in1_0 = 4'h5;
      tick(2);
      u0 = upd_seen;
      reset = 1'b1;
      tick(3);
      check("mid_port1_rst", bus.in_port1, 32'h0);
      check("mid_update_rst", 32'(bus.port_update), 32'h0);
      check("mid_count_rst", 32'(bus.press_count), 32'h0);
      check("mid_update_n0", 32'(upd_seen - u0), 32'd0);
      reset = 1'b0;
      tick(5);
      check("mid_port1_e5", bus.in_port1, 32'h0);
      tick(1);
      check("mid_port1_e6", bus.in_port1, 32'h0000_00A5);
      check("mid_port0_e6", bus.in_port0, 32'h0000_0003);
      check("mid_update_e6", 32'(bus.port_update), 32'h1);
      tick(1);
      check("mid_update_n", 32'(upd_seen - u0), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
